girl10_keyed_fsm: RTL and testbench
===================================

// Module: girl10_keyed_fsm
// PURPOSE
// Parametrised successor to the single-bit-key girl10 locked controller: same 6-state Mealy control
// FSM (S1..S6, outputs y1..y4,y6..y10), locked by a KEY_W-bit key checked on every S5->S1 return.
// Wrong key routes through a DUP_DEPTH-long decoy chain (added latency, zero outputs), counts failures
// and, past CORRUPT_LIMIT, forces all outputs low until a correct key. Used as a benchmark FSM.
// PARAMETERS
// KEY_W          4        key width in bits (>=1)
// KEY_VAL        4'hA     correct key, KEY_W bits
// DUP_DEPTH      2        decoy states D1..D_DUP_DEPTH on wrong key (>=1)
// CORRUPT_LIMIT  3        wrong_cnt value at/above which outputs are forced to 0 (>=1)
// CNT_W          4        wrong-key counter width; 2**CNT_W-1 must be >= CORRUPT_LIMIT
// PORTS
// clk         in   1      clock, rising edge
// rst         in   1      synchronous active-high reset
// x1..x7      in   1 ea   FSM condition inputs
// keyinput    in   KEY_W  unlock key, sampled only in S5 with x5=1
// y1..y4,y6..y10 out 1 ea Mealy outputs (combinational from state + inputs)
// key_ok      out  1      registered; result of most recent key check
// wrong_cnt   out  CNT_W  registered saturating count of wrong-key checks
// BEHAVIOUR
// - State register only is sequential, plus key_ok/wrong_cnt. rst at clk edge: state=S1, key_ok=1, wrong_cnt=0.
// - Outputs default 0 each evaluation; "corrupt" = (wrong_cnt >= CORRUPT_LIMIT) forces every y to 0
//   (transitions unaffected).
// - S1: x6 -> y8,y9, next S2; ~x6&x7 -> y6, next S3; ~x6&~x7 -> y3,y6,y10, next S3.
// - S2: x4&x1 -> y1,y2, stay S2; x4&~x1 -> y3,y4, next S4; ~x4 -> y4, next S5.
// - S3: ~x1 -> y4, next S5; x1&x2&~x3 -> y6,y7, next S6; other x1 cases -> y1,y3, next S2.
// - S4: x6 -> y6,y7, next S3; ~x6 -> y3,y4, stay S4.
// - S5: ~x5&x1 -> y8,y9, next S2; ~x5&~x1 -> y3,y4, next S4; x5 -> no outputs, key check:
//   keyinput==KEY_VAL -> next S1, key_ok<=1, wrong_cnt<=0;
//   else -> next D1, key_ok<=0, wrong_cnt<=wrong_cnt+1 (saturates at all-ones, no wrap).
// - S6: unconditional y3,y4, next S4.
// - Dk (k<DUP_DEPTH): all outputs 0, next D(k+1) regardless of inputs. D_DUP_DEPTH: all outputs 0, next S1.
//   Wrong key therefore costs exactly DUP_DEPTH extra cycles before S1.
// - key_ok/wrong_cnt change only at the S5&x5 key-check edge (or reset).
// - Unused/illegal encodings: outputs 0, next S1.
// - State encoding binary, width $clog2(7+DUP_DEPTH); encoding otherwise implementation-defined.
// - rst dominates every transition, including mid-decoy chain and the key-check edge.
// TESTING (KEY_W=4, KEY_VAL=4'hA, DUP_DEPTH=2, CORRUPT_LIMIT=3, CNT_W=4)
// 1 rst, then x6=1 in S1 -> y8=y9=1, all other y=0; next cycle state S2; key_ok=1, wrong_cnt=0.
// 2 S1(x6=0,x7=1: y6)->S3(x1=0: y4)->S5; x5=1,keyinput=4'hA -> next S1, key_ok=1, wrong_cnt=0.
// 3 Same path, keyinput=4'h5 -> D1, D2 (all y=0 two cycles), then S1; key_ok=0, wrong_cnt=1.
// 4 Three wrong checks -> wrong_cnt=3; in S2 with x4=x1=1 y1=y2=0 (corrupt), state still S2;
//   next correct check -> wrong_cnt=0, S2 with x4=x1=1 gives y1=y2=1.
// 5 rst=1 while in D1 with wrong_cnt=2 -> next edge state S1, wrong_cnt=0, key_ok=1, no D2 visit.
// 6 S3 with x1=1,x2=1,x3=0 -> y6=y7=1, next S6 -> y3=y4=1 any inputs, next S4; 17 wrong checks -> wrong_cnt stays 15.

Source files
------------

// File: rtl/girl10_keyed_fsm.sv
// rtl/girl10_keyed_fsm.sv - key-locked 6-state Mealy controller with decoy chain and failure counter
module girl10_keyed_fsm #(
  parameter int               KEY_W         = 4,
  parameter logic [KEY_W-1:0] KEY_VAL       = 4'hA,
  parameter int               DUP_DEPTH     = 2,
  parameter int               CORRUPT_LIMIT = 3,
  parameter int               CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  input  logic             x4,
  input  logic             x5,
  input  logic             x6,
  input  logic             x7,
  input  logic [KEY_W-1:0] keyinput,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             y4,
  output logic             y6,
  output logic             y7,
  output logic             y8,
  output logic             y9,
  output logic             y10,
  output logic             key_ok,
  output logic [CNT_W-1:0] wrong_cnt
);

  localparam int SW = $clog2(7 + DUP_DEPTH);
  localparam logic [SW-1:0] D_LAST = SW'(5 + DUP_DEPTH);

  // Output vector order: {y1,y2,y3,y4,y6,y7,y8,y9,y10}
  localparam logic [8:0] Y1  = 9'h100;
  localparam logic [8:0] Y2  = 9'h080;
  localparam logic [8:0] Y3  = 9'h040;
  localparam logic [8:0] Y4  = 9'h020;
  localparam logic [8:0] Y6  = 9'h010;
  localparam logic [8:0] Y7  = 9'h008;
  localparam logic [8:0] Y8  = 9'h004;
  localparam logic [8:0] Y9  = 9'h002;
  localparam logic [8:0] Y10 = 9'h001;

  // Decoy states occupy D1 .. D1+DUP_DEPTH-1; higher codes are illegal.
  typedef enum logic [SW-1:0] {S1, S2, S3, S4, S5, S6, D1} state_e;

  state_e           state_q, state_d;
  logic             key_ok_q, key_ok_d;
  logic [CNT_W-1:0] wrong_cnt_q, wrong_cnt_d;
  logic [8:0]       y_raw;
  logic [8:0]       y_out;
  logic             corrupt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S1;
      key_ok_q    <= 1'b1;
      wrong_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      key_ok_q    <= key_ok_d;
      wrong_cnt_q <= wrong_cnt_d;
    end
  end

  always_comb begin
    state_d     = S1;
    y_raw       = '0;
    key_ok_d    = key_ok_q;
    wrong_cnt_d = wrong_cnt_q;
    case (state_q)
      S1: begin
        if (x6) begin
          y_raw   = Y8 | Y9;
          state_d = S2;
        end else if (x7) begin
          y_raw   = Y6;
          state_d = S3;
        end else begin
          y_raw   = Y3 | Y6 | Y10;
          state_d = S3;
        end
      end
      S2: begin
        if (x4 && x1) begin
          y_raw   = Y1 | Y2;
          state_d = S2;
        end else if (x4) begin
          y_raw   = Y3 | Y4;
          state_d = S4;
        end else begin
          y_raw   = Y4;
          state_d = S5;
        end
      end
      S3: begin
        if (!x1) begin
          y_raw   = Y4;
          state_d = S5;
        end else if (x2 && !x3) begin
          y_raw   = Y6 | Y7;
          state_d = S6;
        end else begin
          y_raw   = Y1 | Y3;
          state_d = S2;
        end
      end
      S4: begin
        if (x6) begin
          y_raw   = Y6 | Y7;
          state_d = S3;
        end else begin
          y_raw   = Y3 | Y4;
          state_d = S4;
        end
      end
      S5: begin
        if (x5) begin
          if (keyinput == KEY_VAL) begin
            state_d     = S1;
            key_ok_d    = 1'b1;
            wrong_cnt_d = '0;
          end else begin
            state_d  = D1;
            key_ok_d = 1'b0;
            if (wrong_cnt_q != {CNT_W{1'b1}}) begin
              wrong_cnt_d = wrong_cnt_q + 1'b1;
            end
          end
        end else if (x1) begin
          y_raw   = Y8 | Y9;
          state_d = S2;
        end else begin
          y_raw   = Y3 | Y4;
          state_d = S4;
        end
      end
      S6: begin
        y_raw   = Y3 | Y4;
        state_d = S4;
      end
      default: begin
        // Last decoy and illegal codes both fall back to S1 via the default above.
        if (state_q >= D1 && state_q < D_LAST) begin
          state_d = state_e'(state_q + 1'b1);
        end
      end
    endcase
  end

  assign corrupt = (wrong_cnt_q >= CNT_W'(CORRUPT_LIMIT));
  assign y_out   = corrupt ? 9'h000 : y_raw;

  assign {y1, y2, y3, y4, y6, y7, y8, y9, y10} = y_out;
  assign key_ok    = key_ok_q;
  assign wrong_cnt = wrong_cnt_q;

endmodule

// File: tb/tb_girl10_keyed_fsm.sv
// tb/tb_girl10_keyed_fsm.sv - scoreboard bench for girl10_keyed_fsm with directed vectors
module tb_girl10_keyed_fsm;

  localparam logic [8:0] Y1  = 9'h100;
  localparam logic [8:0] Y2  = 9'h080;
  localparam logic [8:0] Y3  = 9'h040;
  localparam logic [8:0] Y4  = 9'h020;
  localparam logic [8:0] Y6  = 9'h010;
  localparam logic [8:0] Y7  = 9'h008;
  localparam logic [8:0] Y8  = 9'h004;
  localparam logic [8:0] Y9  = 9'h002;
  localparam logic [8:0] Y10 = 9'h001;
  localparam logic [8:0] Y0  = 9'h000;

  localparam logic [6:0] X1 = 7'h01;
  localparam logic [6:0] X2 = 7'h02;
  localparam logic [6:0] X4 = 7'h08;
  localparam logic [6:0] X5 = 7'h10;
  localparam logic [6:0] X6 = 7'h20;
  localparam logic [6:0] X7 = 7'h40;
  localparam logic [6:0] XA = 7'h7F;
  localparam logic [6:0] X0 = 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] xv  = '0;
  logic [3:0] keyinput = '0;
  logic       y1, y2, y3, y4, y6, y7, y8, y9, y10;
  logic       key_ok;
  logic [3:0] wrong_cnt;

  typedef struct {
    string      name;
    logic [8:0] y;
    logic       kok;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  girl10_keyed_fsm #(
    .KEY_W(4), .KEY_VAL(4'hA), .DUP_DEPTH(2), .CORRUPT_LIMIT(3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .x1(xv[0]), .x2(xv[1]), .x3(xv[2]), .x4(xv[3]), .x5(xv[4]), .x6(xv[5]), .x7(xv[6]),
    .keyinput(keyinput),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y6(y6), .y7(y7), .y8(y8), .y9(y9), .y10(y10),
    .key_ok(key_ok), .wrong_cnt(wrong_cnt)
  );

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] yact;
      e    = sb.pop_front();
      yact = {y1, y2, y3, y4, y6, y7, y8, y9, y10};
      checks++;
      if (yact !== e.y) begin
        failures++;
        $display("FAIL %s y: got %03h expected %03h", e.name, yact, e.y);
      end
      checks++;
      if (key_ok !== e.kok) begin
        failures++;
        $display("FAIL %s key_ok: got %0b expected %0b", e.name, key_ok, e.kok);
      end
      checks++;
      if (wrong_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s wrong_cnt: got %0d expected %0d", e.name, wrong_cnt, e.cnt);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic [6:0] x, input logic [3:0] k,
                     input logic [8:0] ey, input logic ek, input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    xv       = x;
    keyinput = k;
    e.name = nm;
    e.y    = ey;
    e.kok  = ek;
    e.cnt  = ec;
    sb.push_back(e);
  endtask

  initial begin
    int       c;
    logic     kok;
    logic [8:0] ya, yb;
    rst = 1'b1;
    @(posedge clk);
    // Second reset cycle: state already S1, x=0 path visible.
    cyc("reset_s1",     1, X0, 4'h0, Y3 | Y6 | Y10, 1, 0);
    // Test 1 and general transition coverage
    cyc("s1_x6",        0, X6, 4'h0, Y8 | Y9, 1, 0);
    cyc("s2_nx4",       0, X0, 4'h0, Y4, 1, 0);
    cyc("s5_x1",        0, X1, 4'h0, Y8 | Y9, 1, 0);
    cyc("s2_x4nx1",     0, X4, 4'h0, Y3 | Y4, 1, 0);
    cyc("s4_stay",      0, X0, 4'h0, Y3 | Y4, 1, 0);
    cyc("s4_x6",        0, X6, 4'h0, Y6 | Y7, 1, 0);
    cyc("s3_other",     0, X1, 4'h0, Y1 | Y3, 1, 0);
    cyc("s2_x4x1",      0, X4 | X1, 4'h0, Y1 | Y2, 1, 0);
    cyc("s2_to_s5",     0, X0, 4'h0, Y4, 1, 0);
    cyc("s5_nx1",       0, X0, 4'h0, Y3 | Y4, 1, 0);
    cyc("s4_x6b",       0, X6, 4'h0, Y6 | Y7, 1, 0);
    cyc("s3_nx1",       0, X0, 4'h0, Y4, 1, 0);
    // Test 2: correct key
    cyc("key_ok_chk",   0, X5, 4'hA, Y0, 1, 0);
    cyc("s1_x7",        0, X7, 4'h0, Y6, 1, 0);
    cyc("s3_to_s5",     0, X0, 4'h0, Y4, 1, 0);
    // Test 3: wrong key, two decoy cycles then S1
    cyc("wrong1_chk",   0, X5, 4'h5, Y0, 1, 0);
    cyc("d1_ones",      0, XA, 4'hA, Y0, 0, 1);
    cyc("d2",           0, X6, 4'h0, Y0, 0, 1);
    cyc("s1_after_d",   0, X6, 4'h0, Y8 | Y9, 0, 1);
    // Test 4: reach corrupt
    cyc("s2_to_s5_w2",  0, X0, 4'h0, Y4, 0, 1);
    cyc("wrong2_chk",   0, X5, 4'h0, Y0, 0, 1);
    cyc("d1_w2",        0, X0, 4'h0, Y0, 0, 2);
    cyc("d2_w2",        0, X0, 4'h0, Y0, 0, 2);
    cyc("s1_x7_w2",     0, X7, 4'h0, Y6, 0, 2);
    cyc("s3_to_s5_w3",  0, X0, 4'h0, Y4, 0, 2);
    cyc("wrong3_chk",   0, X5, 4'hB, Y0, 0, 2);
    cyc("d1_w3",        0, X0, 4'h0, Y0, 0, 3);
    cyc("d2_w3",        0, X0, 4'h0, Y0, 0, 3);
    cyc("corrupt_s1",   0, X6, 4'h0, Y0, 0, 3);
    cyc("corrupt_s2a",  0, X4 | X1, 4'h0, Y0, 0, 3);
    cyc("corrupt_s2b",  0, X4 | X1, 4'h0, Y0, 0, 3);
    cyc("corrupt_s2c",  0, X0, 4'h0, Y0, 0, 3);
    cyc("unlock_chk",   0, X5, 4'hA, Y0, 0, 3);
    cyc("unlock_s1",    0, X6, 4'h0, Y8 | Y9, 1, 0);
    cyc("unlock_s2",    0, X4 | X1, 4'h0, Y1 | Y2, 1, 0);
    // Test 5: reset in D1 with wrong_cnt=2
    cyc("t5_s2",        0, X0, 4'h0, Y4, 1, 0);
    cyc("t5_w1",        0, X5, 4'h1, Y0, 1, 0);
    cyc("t5_d1",        0, X0, 4'h0, Y0, 0, 1);
    cyc("t5_d2",        0, X0, 4'h0, Y0, 0, 1);
    cyc("t5_s1",        0, X6, 4'h0, Y8 | Y9, 0, 1);
    cyc("t5_s2b",       0, X0, 4'h0, Y4, 0, 1);
    cyc("t5_w2",        0, X5, 4'h2, Y0, 0, 1);
    cyc("t5_rst_in_d1", 1, X0, 4'h0, Y0, 0, 2);
    cyc("t5_after_rst", 0, X0, 4'h0, Y3 | Y6 | Y10, 1, 0);
    // Test 6: S3->S6->S4, then saturating counter
    cyc("s3_to_s6",     0, X1 | X2, 4'h0, Y6 | Y7, 1, 0);
    cyc("s6_any",       0, XA, 4'h0, Y3 | Y4, 1, 0);
    cyc("s4_to_s3",     0, X6, 4'h0, Y6 | Y7, 1, 0);
    cyc("s3_to_s5_t6",  0, X0, 4'h0, Y4, 1, 0);
    c   = 0;
    kok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc("sat_chk", 0, X5, 4'h3, Y0, kok, 4'(c));
      c   = (c == 15) ? 15 : c + 1;
      kok = 1'b0;
      ya  = (c >= 3) ? Y0 : (Y8 | Y9);
      yb  = (c >= 3) ? Y0 : Y4;
      cyc("sat_d1", 0, X0, 4'h0, Y0, 0, 4'(c));
      cyc("sat_d2", 0, X0, 4'h0, Y0, 0, 4'(c));
      cyc("sat_s1", 0, X6, 4'h0, ya, 0, 4'(c));
      cyc("sat_s2", 0, X0, 4'h0, yb, 0, 4'(c));
    end
    cyc("sat_final",    0, X5, 4'hA, Y0, 0, 15);
    cyc("sat_unlock",   0, X6, 4'h0, Y8 | Y9, 1, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
